cnn_conv_1x1_weight_feeder: RTL and testbench
=============================================

// Module: cnn_conv_1x1_weight_feeder
// PURPOSE
//  Transmit side of the valid_weight_in/weight_in stream consumed by the cnn_conv_1x1_* layers.
//  On a start pulse it reads CHANNEL_NUM_IN*CHANNEL_NUM_OUT weights from a sync-read weight memory.
//  Weights are streamed in address order, one per cycle, grouped per output channel (in-ch fastest).
//  Sits between the weight ROM/BRAM and the conv layer's weight port.
// PARAMETERS
//  DATA_WIDTH      32   weight word width, same as the conv layer
//  CHANNEL_NUM_IN  128  weights per output-channel group
//  CHANNEL_NUM_OUT 512  number of groups
//  ADDR_WIDTH      16   weight memory address width
//  BASE_ADDR       0    address of first weight
// PORTS
//  clk               in   1           single clock, all logic on posedge
//  reset             in   1           asynchronous, active-low; 0 = reset
//  start             in   1           1-cycle request to stream one full weight set
//  hold              in   1           1 = pause stream (back-pressure from consumer)
//  mem_rd_en         out  1           memory read strobe (registered)
//  mem_addr          out  ADDR_WIDTH  memory read address (registered)
//  mem_rdata         in   DATA_WIDTH  read data, valid the cycle after mem_rd_en
//  valid_weight_out  out  1           weight_out valid; drives conv valid_weight_in
//  weight_out        out  DATA_WIDTH  weight word; drives conv weight_in
//  weight_last       out  1           with valid: last weight of current out-ch group
//  busy              out  1           1 from start accept until done
//  done              out  1           1-cycle pulse after final weight
// BEHAVIOUR
//  Reset (reset=0, async): all outputs 0, counters 0, FSM=IDLE; held until reset=1.
//  N = CHANNEL_NUM_IN*CHANNEL_NUM_OUT; addresses BASE_ADDR..BASE_ADDR+N-1, mod 2^ADDR_WIDTH (wraps).
//  FSM IDLE -> RUN on start=1; RUN -> DRAIN when read N issued; DRAIN -> DONE when weight N emitted;
//   DONE -> IDLE after 1 cycle (done=1, busy=0 in that cycle).
//  start ignored unless FSM=IDLE; start in DONE cycle also ignored (next cycle is IDLE).
//  Latency, no hold:
//   start sampled at edge E0; mem_rd_en=1, mem_addr=BASE after E0;
//   mem_rdata captured at E2; first valid_weight_out=1 after E2.
//   -> 2 cycles from start to first valid; then 1 weight/cycle, gap-free for N cycles.
//  busy=1 from the cycle after start accept through the last-weight cycle.
//  weight_last=1 on every CHANNEL_NUM_IN-th emitted weight (group k ends at index k*CIN-1).
//  hold: sampled each edge.
//   - While hold=1: no new read issued; valid_weight_out=0 in the cycle after each hold=1 edge.
//   - Reads already in flight (max 2) are kept in an internal 2-entry skid buffer.
//   - On hold release: skid contents emitted first, in order, then reads resume.
//   - Never lose, duplicate or reorder a weight.
//   - hold in IDLE/DONE has no effect.
//  Counters: in-ch idx 0..CIN-1, out-ch idx 0..COUT-1; both advance only on emitted weights.
//  done asserted exactly once per accepted start; weight_out holds last value when valid=0.
//  reset mid-stream: stream aborted, no done pulse; next start restarts from BASE_ADDR.
// TESTING
//  T1 reset=0 for 3 cycles: every output 0.
//   Release, no start for 20 cycles -> mem_rd_en, valid_weight_out, done stay 0.
//  T2 CIN=4, COUT=2, BASE=0x10, memory returns rdata=addr:
//   start -> weights 0x10..0x17 on 8 consecutive cycles, first valid 2 cycles after start.
//   weight_last on 0x13 and 0x17; done pulse 1 cycle after 0x17.
//  T3 as T2, hold=1 for 3 cycles after 3rd weight:
//   valid low exactly during stall; sequence 0x10..0x17 intact; done 3 cycles later than T2.
//  T4 start pulses while busy and in DONE cycle: ignored.
//   Start 1 cycle after done -> second full 8-weight sequence, second done pulse.
//  T5 reset=0 after 5th weight: all outputs 0 immediately.
//   After release + start: stream restarts at 0x10, no done from aborted run.
//  T6 ADDR_WIDTH=4, BASE=14, CIN=2, COUT=2: mem_addr sequence 14,15,0,1; weight_last on 2nd and 4th.

Source files
------------

// File: rtl/cnn_conv_1x1_weight_feeder.sv
// Weight streamer for the cnn_conv_1x1 layers: reads CIN*COUT weights from a sync-read
// memory in address order and presents them on a valid/data stream with hold back-pressure.
module cnn_conv_1x1_weight_feeder #(
  parameter int unsigned           DATA_WIDTH      = 32,
  parameter int unsigned           CHANNEL_NUM_IN  = 128,
  parameter int unsigned           CHANNEL_NUM_OUT = 512,
  parameter int unsigned           ADDR_WIDTH      = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  hold,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  valid_weight_out,
  output logic [DATA_WIDTH-1:0] weight_out,
  output logic                  weight_last,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned N  = CHANNEL_NUM_IN * CHANNEL_NUM_OUT;
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned IW = (CHANNEL_NUM_IN > 1) ? $clog2(CHANNEL_NUM_IN) : 1;
  localparam int unsigned OW = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           rd_cnt;
  logic                    data_vld;
  logic [DATA_WIDTH-1:0]   skid0, skid1;
  logic [1:0]              skid_cnt, skid_cnt_nxt;
  logic [IW-1:0]           in_idx;
  logic [OW-1:0]           out_idx;
  logic                    last_group;
  logic                    active, hold_eff, accept, issue, emit, push, pop;
  logic [DATA_WIDTH-1:0]   emit_data;

  always_comb begin
    active    = (state == RUN) || (state == DRAIN);
    hold_eff  = hold && active;
    accept    = (state == IDLE) && start;
    pop       = !hold_eff && (skid_cnt != 2'd0);
    push      = data_vld && (hold_eff || (skid_cnt != 2'd0));
    emit      = !hold_eff && ((skid_cnt != 2'd0) || data_vld);
    emit_data = (skid_cnt != 2'd0) ? skid0 : mem_rdata;

    skid_cnt_nxt = skid_cnt;
    if (push && !pop)
      skid_cnt_nxt = skid_cnt + 2'd1;
    else if (pop && !push)
      skid_cnt_nxt = skid_cnt - 2'd1;

    // A new read is only safe if the skid can still absorb every in-flight word
    // should hold rise on the next edge and stay high.
    issue = accept ||
            ((state == RUN) && !hold_eff &&
             (({1'b0, skid_cnt_nxt} + {2'b00, mem_rd_en}) <= 3'd1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (N == 1) ? DRAIN : RUN;
      RUN:     if (issue && (rd_cnt == CW'(N - 1))) state_nxt = DRAIN;
      DRAIN:   if (valid_weight_out && weight_last && last_group) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  assign busy = active;
  assign done = (state == DONE);

  // Read side: address generator and in-flight tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      rd_cnt    <= '0;
      data_vld  <= 1'b0;
    end else begin
      mem_rd_en <= issue;
      data_vld  <= mem_rd_en;
      if (accept) begin
        mem_addr <= BASE_ADDR;
        rd_cnt   <= CW'(1);
      end else if (issue) begin
        mem_addr <= mem_addr + 1'b1;
        rd_cnt   <= rd_cnt + 1'b1;
      end
    end
  end

  // Skid buffer: skid0 is always the oldest held word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skid0    <= '0;
      skid1    <= '0;
      skid_cnt <= 2'd0;
    end else begin
      if (push) begin
        if (pop) begin
          if (skid_cnt == 2'd2) begin
            skid0 <= skid1;
            skid1 <= mem_rdata;
          end else begin
            skid0 <= mem_rdata;
          end
        end else if (skid_cnt == 2'd0) begin
          skid0 <= mem_rdata;
        end else begin
          skid1 <= mem_rdata;
        end
      end else if (pop) begin
        skid0 <= skid1;
      end
      skid_cnt <= skid_cnt_nxt;
    end
  end

  // Output stage and channel counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_weight_out <= 1'b0;
      weight_out       <= '0;
      weight_last      <= 1'b0;
      last_group       <= 1'b0;
      in_idx           <= '0;
      out_idx          <= '0;
    end else begin
      valid_weight_out <= emit;
      weight_last      <= emit && (in_idx == IW'(CHANNEL_NUM_IN - 1));
      if (emit) begin
        weight_out <= emit_data;
        last_group <= (out_idx == OW'(CHANNEL_NUM_OUT - 1));
        if (in_idx == IW'(CHANNEL_NUM_IN - 1)) begin
          in_idx  <= '0;
          out_idx <= (out_idx == OW'(CHANNEL_NUM_OUT - 1)) ? '0 : out_idx + 1'b1;
        end else begin
          in_idx <= in_idx + 1'b1;
        end
      end
      if (accept) begin
        in_idx     <= '0;
        out_idx    <= '0;
        last_group <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cnn_conv_1x1_weight_feeder.sv
// Directed bench: two feeder instances (CIN=4/COUT=2/BASE=0x10 and a 4-bit wrapping one)
// driven against behavioural sync-read memories that return rdata = address.
module tb_cnn_conv_1x1_weight_feeder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, hold, start6, hold6;
  logic        mem_rd_en, valid, wlast, busy, done;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata, wout;
  logic        mem_rd_en6, valid6, wlast6, busy6, done6;
  logic [3:0]  mem_addr6;
  logic [31:0] mem_rdata6, wout6;

  int tests = 0;
  int fails = 0;

  cnn_conv_1x1_weight_feeder #(
    .DATA_WIDTH(32), .CHANNEL_NUM_IN(4), .CHANNEL_NUM_OUT(2),
    .ADDR_WIDTH(16), .BASE_ADDR(16'h0010)
  ) u_dut (
    .clk(clk), .reset(rst_n), .start(start), .hold(hold),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .valid_weight_out(valid), .weight_out(wout), .weight_last(wlast),
    .busy(busy), .done(done)
  );

  cnn_conv_1x1_weight_feeder #(
    .DATA_WIDTH(32), .CHANNEL_NUM_IN(2), .CHANNEL_NUM_OUT(2),
    .ADDR_WIDTH(4), .BASE_ADDR(4'd14)
  ) u_dut6 (
    .clk(clk), .reset(rst_n), .start(start6), .hold(hold6),
    .mem_rd_en(mem_rd_en6), .mem_addr(mem_addr6), .mem_rdata(mem_rdata6),
    .valid_weight_out(valid6), .weight_out(wout6), .weight_last(wlast6),
    .busy(busy6), .done(done6)
  );

  always_ff @(posedge clk) begin
    if (mem_rd_en)  mem_rdata  <= {16'h0, mem_addr};
    if (mem_rd_en6) mem_rdata6 <= {28'h0, mem_addr6};
  end

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; hold = 1'b0; start6 = 1'b0; hold6 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      tests++;
      if ({mem_rd_en, mem_addr, valid, wout, wlast, busy, done} !== '0) begin
        fails++;
        $display("FAIL reset_outputs cyc %0d: got rd=%b addr=%h v=%b w=%h l=%b busy=%b done=%b, want all 0",
                 c, mem_rd_en, mem_addr, valid, wout, wlast, busy, done);
      end
      tests++;
      if ({mem_rd_en6, mem_addr6, valid6, wout6, wlast6, busy6, done6} !== '0) begin
        fails++;
        $display("FAIL reset_outputs6 cyc %0d: got nonzero output, want all 0", c);
      end
    end
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      tests++;
      if ({mem_rd_en, valid, done} !== 3'b000) begin
        fails++;
        $display("FAIL idle_quiet cyc %0d: got rd/v/done=%b, want 000", c, {mem_rd_en, valid, done});
      end
    end
  endtask

  task automatic test_stream();
    logic        ev;
    logic [31:0] ew;
    start = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      ev = (k >= 2 && k <= 9);
      ew = 32'(32'h10 + k - 2);
      tests++;
      if (valid !== ev || (ev && wout !== ew)) begin
        fails++;
        $display("FAIL stream_data k=%0d: got v=%b w=%h, want v=%b w=%h", k, valid, wout, ev, ew);
      end
      tests++;
      if (wlast !== (k == 5 || k == 9) || done !== (k == 10) || busy !== (k <= 9)) begin
        fails++;
        $display("FAIL stream_ctrl k=%0d: got last=%b done=%b busy=%b, want %b %b %b",
                 k, wlast, done, busy, (k == 5 || k == 9), (k == 10), (k <= 9));
      end
      tests++;
      if (mem_rd_en !== (k <= 7) || (k <= 7 && mem_addr !== 16'(16'h10 + k))) begin
        fails++;
        $display("FAIL stream_rd k=%0d: got rd=%b addr=%h, want rd=%b addr=%h",
                 k, mem_rd_en, mem_addr, (k <= 7), 16'(16'h10 + k));
      end
    end
  endtask

  task automatic test_hold();
    logic        ev, stall;
    int          idx;
    logic [31:0] ew;
    start = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      stall = (k >= 5 && k <= 7);
      ev    = (k >= 2 && k <= 12) && !stall;
      idx   = (k < 5) ? k - 2 : k - 5;
      ew    = 32'(32'h10 + idx);
      tests++;
      if (valid !== ev || (ev && wout !== ew) || (stall && wout !== 32'h12)) begin
        fails++;
        $display("FAIL hold_data k=%0d: got v=%b w=%h, want v=%b w=%h",
                 k, valid, wout, ev, stall ? 32'h12 : ew);
      end
      tests++;
      if (wlast !== (ev && (idx == 3 || idx == 7)) || done !== (k == 13)) begin
        fails++;
        $display("FAIL hold_ctrl k=%0d: got last=%b done=%b, want %b %b",
                 k, wlast, done, (ev && (idx == 3 || idx == 7)), (k == 13));
      end
      hold = (k >= 4 && k <= 6);
    end
    hold = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic        ev, erd;
    int          ndone;
    logic [31:0] ew;
    ndone = 0;
    start = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      ev  = (k >= 2 && k <= 9) || (k >= 14 && k <= 21);
      ew  = (k < 12) ? 32'(32'h10 + k - 2) : 32'(32'h10 + k - 14);
      erd = (k <= 7) || (k >= 12 && k <= 19);
      if (done) ndone++;
      tests++;
      if (valid !== ev || (ev && wout !== ew)) begin
        fails++;
        $display("FAIL b2b_data k=%0d: got v=%b w=%h, want v=%b w=%h", k, valid, wout, ev, ew);
      end
      tests++;
      if (done !== (k == 10 || k == 22) || mem_rd_en !== erd) begin
        fails++;
        $display("FAIL b2b_ctrl k=%0d: got done=%b rd=%b, want %b %b",
                 k, done, mem_rd_en, (k == 10 || k == 22), erd);
      end
      start = (k == 2 || k == 10 || k == 11);
    end
    start = 1'b0;
    tests++;
    if (ndone != 2) begin
      fails++;
      $display("FAIL b2b_done_count: got %0d, want 2", ndone);
    end
  endtask

  task automatic test_reset_mid();
    logic        ev;
    logic [31:0] ew;
    start = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      tests++;
      if (done !== 1'b0) begin
        fails++;
        $display("FAIL abort_early_done k=%0d: got %b, want 0", k, done);
      end
    end
    tests++;
    if (valid !== 1'b1 || wout !== 32'h14) begin
      fails++;
      $display("FAIL abort_fifth: got v=%b w=%h, want v=1 w=00000014", valid, wout);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({mem_rd_en, mem_addr, valid, wout, wlast, busy, done} !== '0) begin
      fails++;
      $display("FAIL abort_async_reset: got rd=%b addr=%h v=%b w=%h l=%b busy=%b done=%b, want all 0",
               mem_rd_en, mem_addr, valid, wout, wlast, busy, done);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      ev = (k >= 2 && k <= 9);
      ew = 32'(32'h10 + k - 2);
      tests++;
      if (valid !== ev || (ev && wout !== ew) || done !== (k == 10)) begin
        fails++;
        $display("FAIL restart k=%0d: got v=%b w=%h done=%b, want v=%b w=%h done=%b",
                 k, valid, wout, done, ev, ew, (k == 10));
      end
    end
  endtask

  task automatic test_wrap();
    logic       ev;
    logic [3:0] ea;
    start6 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      start6 = 1'b0;
      ea = 4'(14 + k);
      tests++;
      if (mem_rd_en6 !== (k <= 3) || (k <= 3 && mem_addr6 !== ea)) begin
        fails++;
        $display("FAIL wrap_addr k=%0d: got rd=%b addr=%0d, want rd=%b addr=%0d",
                 k, mem_rd_en6, mem_addr6, (k <= 3), ea);
      end
      ev = (k >= 2 && k <= 5);
      ea = 4'(14 + k - 2);
      tests++;
      if (valid6 !== ev || (ev && wout6 !== {28'h0, ea}) ||
          wlast6 !== (k == 3 || k == 5) || done6 !== (k == 6)) begin
        fails++;
        $display("FAIL wrap_out k=%0d: got v=%b w=%h l=%b d=%b, want v=%b w=%h l=%b d=%b",
                 k, valid6, wout6, wlast6, done6, ev, {28'h0, ea}, (k == 3 || k == 5), (k == 6));
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
